// File: rtl/reg_xfer_unit.sv
// reg_xfer_unit: small register file driven by single-command transfers
// (LOAD, MOVE, CLEAR, SWAP) through a valid/ready handshake. Each command
// completes with a one-cycle done pulse, with err flagging rejected commands.
// A rejected command never changes any register.
// Optional feature macro: REG_XFER_SWAP_EN enables SWAP, which adds the temp
// register and the SWAP2 state. Without it, op 11 is rejected with err.
module reg_xfer_unit #(
  parameter int WIDTH = 8,
  parameter int NREGS = 4,
  localparam int IW = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [IW-1:0]    cmd_src,
  input  logic [IW-1:0]    cmd_dst,
  input  logic [WIDTH-1:0] d_in,
  input  logic [IW-1:0]    rd_sel,
  output logic [WIDTH-1:0] rd_data,
  output logic             done,
  output logic             err
);

  localparam logic [1:0]  OP_LOAD  = 2'b00;
  localparam logic [1:0]  OP_MOVE  = 2'b01;
  localparam logic [1:0]  OP_CLEAR = 2'b10;
  localparam logic [1:0]  OP_SWAP  = 2'b11;
  localparam logic [31:0] NREGS_U  = 32'(NREGS);

`ifdef REG_XFER_SWAP_EN
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_EXEC  = 2'd1,
    ST_SWAP2 = 2'd2,
    ST_DONE  = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_EXEC  = 2'd1,
    ST_DONE  = 2'd3
  } state_t;
`endif

  state_t           state_r;
  logic [1:0]       op_r;
  logic [IW-1:0]    src_r;
  logic [IW-1:0]    dst_r;
  logic [WIDTH-1:0] din_r;
  logic [WIDTH-1:0] regs_r [NREGS];
  logic             cmd_ready_r;
  logic             done_r;
  logic             err_r;
`ifdef REG_XFER_SWAP_EN
  logic [WIDTH-1:0] temp_r;
`endif

  logic             dst_bad_s;
  logic             src_bad_s;
  logic             op_bad_s;
  logic             cmd_err_s;

  // Decode whether the captured command must be rejected (bad index or unsupported op).
  always_comb begin
    dst_bad_s = 1'b0;
    src_bad_s = 1'b0;
    op_bad_s  = 1'b0;
    if (32'(dst_r) >= NREGS_U) begin
      dst_bad_s = 1'b1;
    end else begin
      dst_bad_s = 1'b0;
    end
    // Only MOVE and SWAP actually read the source index.
    if (((op_r == OP_MOVE) || (op_r == OP_SWAP)) && (32'(src_r) >= NREGS_U)) begin
      src_bad_s = 1'b1;
    end else begin
      src_bad_s = 1'b0;
    end
`ifndef REG_XFER_SWAP_EN
    if (op_r == OP_SWAP) begin
      op_bad_s = 1'b1;
    end else begin
      op_bad_s = 1'b0;
    end
`endif
    cmd_err_s = dst_bad_s | src_bad_s | op_bad_s;
  end

  // Command FSM: capture on acceptance, sequence EXEC/SWAP2/DONE, drive registered handshake flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= ST_IDLE;
      cmd_ready_r <= 1'b1;
      done_r      <= 1'b0;
      err_r       <= 1'b0;
      op_r        <= 2'b00;
      src_r       <= {IW{1'b0}};
      dst_r       <= {IW{1'b0}};
      din_r       <= {WIDTH{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (cmd_valid) begin
            op_r        <= cmd_op;
            src_r       <= cmd_src;
            dst_r       <= cmd_dst;
            din_r       <= d_in;
            state_r     <= ST_EXEC;
            cmd_ready_r <= 1'b0;
          end else begin
            state_r     <= ST_IDLE;
            cmd_ready_r <= 1'b1;
          end
        end
        ST_EXEC: begin
`ifdef REG_XFER_SWAP_EN
          if (!cmd_err_s && (op_r == OP_SWAP)) begin
            state_r <= ST_SWAP2;
          end else begin
            state_r <= ST_DONE;
            done_r  <= 1'b1;
            err_r   <= cmd_err_s;
          end
`else
          state_r <= ST_DONE;
          done_r  <= 1'b1;
          err_r   <= cmd_err_s;
`endif
        end
`ifdef REG_XFER_SWAP_EN
        ST_SWAP2: begin
          state_r <= ST_DONE;
          done_r  <= 1'b1;
          err_r   <= 1'b0;
        end
`endif
        ST_DONE: begin
          state_r     <= ST_IDLE;
          done_r      <= 1'b0;
          err_r       <= 1'b0;
          cmd_ready_r <= 1'b1;
        end
        default: begin
          state_r     <= ST_IDLE;
          done_r      <= 1'b0;
          err_r       <= 1'b0;
          cmd_ready_r <= 1'b1;
        end
      endcase
    end
  end

  // Register file update: writes happen only when leaving EXEC (and SWAP2) for a valid command.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_r[i] <= {WIDTH{1'b0}};
      end
`ifdef REG_XFER_SWAP_EN
      temp_r <= {WIDTH{1'b0}};
`endif
    end else begin
      case (state_r)
        ST_EXEC: begin
          if (!cmd_err_s) begin
            case (op_r)
              OP_LOAD:  regs_r[dst_r] <= din_r;
              OP_MOVE:  regs_r[dst_r] <= regs_r[src_r];
              OP_CLEAR: regs_r[dst_r] <= {WIDTH{1'b0}};
`ifdef REG_XFER_SWAP_EN
              // First half of the swap; src==dst rewrites the same value.
              OP_SWAP: begin
                temp_r        <= regs_r[src_r];
                regs_r[src_r] <= regs_r[dst_r];
              end
`endif
              default: begin
              end
            endcase
          end
        end
`ifdef REG_XFER_SWAP_EN
        ST_SWAP2: begin
          regs_r[dst_r] <= temp_r;
        end
`endif
        default: begin
        end
      endcase
    end
  end

  // Combinational read port; indices beyond the register count read as zero.
  always_comb begin
    rd_data = {WIDTH{1'b0}};
    if (32'(rd_sel) < NREGS_U) begin
      rd_data = regs_r[rd_sel];
    end else begin
      rd_data = {WIDTH{1'b0}};
    end
  end

  assign cmd_ready = cmd_ready_r;
  assign done      = done_r;
  assign err       = err_r;

endmodule

// File: tb/tb_reg_xfer_unit.sv
// Testbench for reg_xfer_unit: two instances (NREGS=4 and NREGS=3) receive the
// same command stream; a packed-vector reference model per instance predicts
// register contents, err and completion latency. Follows REG_XFER_SWAP_EN.
module tb_reg_xfer_unit;

`ifdef REG_XFER_SWAP_EN
  localparam bit SWAP_EN = 1'b1;
`else
  localparam bit SWAP_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       cmd_valid = 1'b0;
  logic [1:0] cmd_op = 2'b00;
  logic [1:0] cmd_src = 2'b00;
  logic [1:0] cmd_dst = 2'b00;
  logic [7:0] d_in = 8'h00;
  logic [1:0] rd_sel = 2'b00;

  logic       rdy4, done4, err4;
  logic       rdy3, done3, err3;
  logic [7:0] rd4, rd3;

  int checks_cnt = 0;
  int errors_cnt = 0;

  // Reference register images, one byte per register.
  logic [31:0] m4 = 32'h0;
  logic [31:0] m3 = 32'h0;

  always #5 clk = ~clk;

  reg_xfer_unit #(.WIDTH(8), .NREGS(4)) u_dut4 (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(rdy4),
    .cmd_op(cmd_op), .cmd_src(cmd_src), .cmd_dst(cmd_dst), .d_in(d_in),
    .rd_sel(rd_sel), .rd_data(rd4), .done(done4), .err(err4)
  );

  reg_xfer_unit #(.WIDTH(8), .NREGS(3)) u_dut3 (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(rdy3),
    .cmd_op(cmd_op), .cmd_src(cmd_src), .cmd_dst(cmd_dst), .d_in(d_in),
    .rd_sel(rd_sel), .rd_data(rd3), .done(done3), .err(err3)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks_cnt++;
    if (act !== exp) begin
      errors_cnt++;
      $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
    end
  endtask

  // Reference model: new register image, error flag and done latency of one command.
  function automatic logic [31:0] mdl_next(input logic [31:0] r, input int n,
                                           input logic [1:0] op, input logic [1:0] src,
                                           input logic [1:0] dst, input logic [7:0] din,
                                           output bit e, output int lat);
    logic [31:0] q;
    int s;
    int d;
    q = r;
    s = int'(src);
    d = int'(dst);
    e = (d >= n) || (((op == 2'd1) || (op == 2'd3)) && (s >= n)) || ((op == 2'd3) && !SWAP_EN);
    lat = ((op == 2'd3) && !e) ? 3 : 2;
    if (!e) begin
      case (op)
        2'd0:    q[8*d +: 8] = din;
        2'd1:    q[8*d +: 8] = r[8*s +: 8];
        2'd2:    q[8*d +: 8] = 8'h00;
        default: begin
          q[8*d +: 8] = r[8*s +: 8];
          q[8*s +: 8] = r[8*d +: 8];
        end
      endcase
    end
    return q;
  endfunction

  // Read every register through rd_sel and compare against the model images.
  task automatic sweep(input string tag, input bit do4, input bit do3);
    logic [7:0] exp3;
    for (int i = 0; i < 4; i++) begin
      rd_sel = 2'(i);
      #1;
      if (do4) check_eq($sformatf("%s_rd4_r%0d", tag, i), 32'(rd4), 32'(m4[8*i +: 8]));
      exp3 = (i < 3) ? m3[8*i +: 8] : 8'h00;
      if (do3) check_eq($sformatf("%s_rd3_r%0d", tag, i), 32'(rd3), 32'(exp3));
    end
  endtask

  // Issue one command from a negedge and follow it to completion in both instances.
  // keep_valid: after acceptance, present the next command with cmd_valid held high.
  task automatic do_cmd(input string tag, input logic [1:0] op, input logic [1:0] src,
                        input logic [1:0] dst, input logic [7:0] din, input bit keep_valid,
                        input logic [1:0] nop, input logic [1:0] nsrc, input logic [1:0] ndst,
                        input logic [7:0] ndin);
    bit e4, e3;
    int l4, l3, lmax;
    cmd_op = op; cmd_src = src; cmd_dst = dst; d_in = din; cmd_valid = 1'b1;
    #1;
    check_eq({tag, "_ready4"}, 32'(rdy4), 32'd1);
    check_eq({tag, "_ready3"}, 32'(rdy3), 32'd1);
    m4 = mdl_next(m4, 4, op, src, dst, din, e4, l4);
    m3 = mdl_next(m3, 3, op, src, dst, din, e3, l3);
    lmax = ((l4 > l3) ? l4 : l3) + 1;
    @(posedge clk);
    for (int n = 1; n <= lmax; n++) begin
      @(negedge clk);
      check_eq($sformatf("%s_done4_c%0d", tag, n), 32'(done4), 32'(n == l4));
      check_eq($sformatf("%s_err4_c%0d", tag, n), 32'(err4), 32'((n == l4) && e4));
      check_eq($sformatf("%s_ready4_c%0d", tag, n), 32'(rdy4), 32'(n > l4));
      check_eq($sformatf("%s_done3_c%0d", tag, n), 32'(done3), 32'(n == l3));
      check_eq($sformatf("%s_err3_c%0d", tag, n), 32'(err3), 32'((n == l3) && e3));
      check_eq($sformatf("%s_ready3_c%0d", tag, n), 32'(rdy3), 32'(n > l3));
      if (n == 1) begin
        if (keep_valid) begin
          cmd_op = nop; cmd_src = nsrc; cmd_dst = ndst; d_in = ndin; cmd_valid = 1'b1;
        end else begin
          // Scramble inputs to show the command in flight is unaffected.
          cmd_op = 2'($urandom_range(0, 3));
          cmd_src = 2'($urandom_range(0, 3));
          cmd_dst = 2'($urandom_range(0, 3));
          d_in = 8'($urandom_range(0, 255));
          cmd_valid = 1'b0;
        end
      end
      if ((n == l4) || (n == l3)) sweep(tag, n == l4, n == l3);
    end
  endtask

  task automatic cmd(input string tag, input logic [1:0] op, input logic [1:0] src,
                     input logic [1:0] dst, input logic [7:0] din);
    do_cmd(tag, op, src, dst, din, 1'b0, 2'b00, 2'b00, 2'b00, 8'h00);
  endtask

  initial begin
    // Reset state.
    rst = 1'b0;
    #1;
    check_eq("rst_done4", 32'(done4), 32'd0);
    check_eq("rst_err4", 32'(err4), 32'd0);
    check_eq("rst_done3", 32'(done3), 32'd0);
    check_eq("rst_err3", 32'(err3), 32'd0);
    sweep("rst", 1'b1, 1'b1);
    @(negedge clk);
    rst = 1'b1;

    // First command right after release; LOAD then directed transfers.
    cmd("load_a5", 2'd0, 2'd0, 2'd2, 8'hA5);
    cmd("load_3c", 2'd0, 2'd0, 2'd1, 8'h3C);
    cmd("move_1_3", 2'd1, 2'd1, 2'd3, 8'h00);
    cmd("load_11", 2'd0, 2'd0, 2'd0, 8'h11);
    cmd("load_22", 2'd0, 2'd0, 2'd2, 8'h22);
    cmd("swap_0_2", 2'd3, 2'd0, 2'd2, 8'h00);
    cmd("swap_1_1", 2'd3, 2'd1, 2'd1, 8'h00);
    cmd("load_dst3", 2'd0, 2'd0, 2'd3, 8'h77);
    cmd("move_3_0", 2'd1, 2'd3, 2'd0, 8'h00);
    cmd("clear_2", 2'd2, 2'd0, 2'd2, 8'h00);

    // Back-to-back with cmd_valid held high.
    do_cmd("b2b_a", 2'd0, 2'd0, 2'd0, 8'h01, 1'b1, 2'd0, 2'd0, 2'd1, 8'h02);
    cmd("b2b_b", 2'd0, 2'd0, 2'd1, 8'h02);

    // Reset in the cycle after accepting LOAD 0xFF to R0.
    cmd_op = 2'd0; cmd_src = 2'd0; cmd_dst = 2'd0; d_in = 8'hFF; cmd_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    rst = 1'b0;
    m4 = 32'h0;
    m3 = 32'h0;
    sweep("abort", 1'b1, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    for (int n = 1; n <= 3; n++) begin
      @(negedge clk);
      check_eq($sformatf("abort_done4_c%0d", n), 32'(done4), 32'd0);
      check_eq($sformatf("abort_done3_c%0d", n), 32'(done3), 32'd0);
      check_eq($sformatf("abort_ready4_c%0d", n), 32'(rdy4), 32'd1);
    end
    cmd("after_abort", 2'd0, 2'd0, 2'd3, 8'h5A);

    // Randomized command stream.
    for (int k = 0; k < 60; k++) begin
      cmd($sformatf("rnd%0d", k), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
          2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)));
    end

    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end

endmodule
